// File: rtl/cp_bypass_sb.sv
// cp_bypass_sb: latency scoreboard and operand bypass network for a single-issue pipeline.
// Optional write-back port forwarding is enabled by defining CP_BYPASS_SB_WB_FWD_EN.
module cp_bypass_sb #(
    parameter int DATA_WIDTH     = 32,
    parameter int RF_INDEX_WIDTH = 5,
    parameter int NUM_RD_PORTS   = 2,
    parameter int MAX_LAT        = 3
) (
    input  logic                                   iClk,
    input  logic                                   iReset,
    input  logic                                   iIssue_Valid,
    input  logic                                   iIssue_Wr,
    input  logic [RF_INDEX_WIDTH-1:0]              iIssue_Dst,
    input  logic [1:0]                             iIssue_Src,
    input  logic [2:0]                             iIssue_Lat,
    input  logic [NUM_RD_PORTS-1:0]                iRd_En,
    input  logic [NUM_RD_PORTS*RF_INDEX_WIDTH-1:0] iRd_Addr,
    input  logic [NUM_RD_PORTS*DATA_WIDTH-1:0]     iRF_Data,
    input  logic [4*DATA_WIDTH-1:0]                iSrc_Data,
    input  logic [RF_INDEX_WIDTH-1:0]              iWB_Addr,
    input  logic [DATA_WIDTH-1:0]                  iWB_Data,
    input  logic                                   iFlush,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]     oOperand,
    output logic                                   oStall,
    output logic                                   oBusy
);
    localparam logic [2:0] MAX_L = 3'(MAX_LAT);

    logic [MAX_LAT-1:0]        valid;
    logic [RF_INDEX_WIDTH-1:0] dst [MAX_LAT];
    logic [1:0]                src [MAX_LAT];
    logic [2:0]                cnt [MAX_LAT];

    logic [2:0]              lat;
    logic [MAX_LAT-1:0]      ready;
    logic [MAX_LAT-1:0]      free;
    logic [MAX_LAT-1:0]      pick;
    logic [NUM_RD_PORTS-1:0] hazard;
    logic                    waw;
    logic                    conflict;
    logic                    taken;
    logic                    alloc;

    assign lat = (iIssue_Lat == 3'd0) ? 3'd1 : (iIssue_Lat > MAX_L) ? MAX_L : iIssue_Lat;

    // An entry completing this cycle frees its slot for an allocation at the same edge.
    always_comb begin
        ready    = '0;
        free     = '0;
        pick     = '0;
        waw      = 1'b0;
        conflict = 1'b0;
        taken    = 1'b0;
        for (int e = 0; e < MAX_LAT; e++) begin
            ready[e] = valid[e] && cnt[e] == 3'd1;
            free[e]  = !valid[e] || cnt[e] == 3'd1;
            waw      = waw || (valid[e] && dst[e] == iIssue_Dst);
            conflict = conflict || (valid[e] && {1'b0, cnt[e]} == {1'b0, lat} + 4'd1);
            if (free[e] && !taken) begin
                pick[e] = 1'b1;
                taken   = 1'b1;
            end
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        logic [RF_INDEX_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]     rf;
        logic [DATA_WIDTH-1:0]     byp;
        logic [MAX_LAT-1:0]        hit;
        logic                      active;
        logic                      wb_hit;
        assign addr   = iRd_Addr[p*RF_INDEX_WIDTH +: RF_INDEX_WIDTH];
        assign rf     = iRF_Data[p*DATA_WIDTH +: DATA_WIDTH];
        assign active = iRd_En[p] && addr != '0;
        always_comb begin
            hit = '0;
            byp = '0;
            for (int e = 0; e < MAX_LAT; e++) begin
                hit[e] = valid[e] && dst[e] == addr;
                if (hit[e] && ready[e])
                    byp = iSrc_Data[int'(src[e])*DATA_WIDTH +: DATA_WIDTH];
            end
        end
`ifdef CP_BYPASS_SB_WB_FWD_EN
        assign wb_hit = active && addr == iWB_Addr;
`else
        assign wb_hit = 1'b0;
`endif
        assign hazard[p] = active && |(hit & ~ready);
        assign oOperand[p*DATA_WIDTH +: DATA_WIDTH] = !active ? rf :
                                                      |(hit & ready) ? byp :
                                                      wb_hit ? iWB_Data : rf;
    end

`ifndef CP_BYPASS_SB_WB_FWD_EN
    logic unused_wb;
    assign unused_wb = ^{iWB_Addr, iWB_Data};
`endif

    assign oStall = iIssue_Valid && (|hazard || (iIssue_Wr && waw) || conflict);
    assign alloc  = iIssue_Valid && !oStall && !iFlush && iIssue_Wr && iIssue_Dst != '0;

    always_ff @(posedge iClk) begin
        if (iReset || iFlush) begin
            valid <= '0;
            oBusy <= 1'b0;
        end else begin
            for (int e = 0; e < MAX_LAT; e++) begin
                if (alloc && pick[e]) begin
                    valid[e] <= 1'b1;
                    dst[e]   <= iIssue_Dst;
                    src[e]   <= iIssue_Src;
                    cnt[e]   <= lat;
                end else if (valid[e]) begin
                    valid[e] <= cnt[e] != 3'd1;
                    cnt[e]   <= cnt[e] - 3'd1;
                end
            end
            oBusy <= alloc || |(valid & ~ready);
        end
    end
endmodule
